stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised N:1 streaming multiplexer with a registered output and a valid/ready handshake.
//  Successor to the fixed 16:1 single-bit combinational mux: adds a configurable data width
//  and channel count, plus fixed-select and round-robin arbitration modes.
//  Sits between N producer channels and one consumer.
// PARAMETERS
//  N_CH   16               number of input channels (>=2)
//  DW     8                data width per channel
//  SELW   $clog2(N_CH)     select/channel-index width (derived; do not override)
// PORTS
//  clk       in   1         rising-edge clock
//  rst       in   1         synchronous, active-high reset
//  in_data   in   N_CH*DW   channel c occupies bits [c*DW +: DW]
//  in_valid  in   N_CH      per-channel valid
//  in_ready  out  N_CH      per-channel ready (combinational)
//  mode      in   1         0 = fixed select via sel; 1 = round-robin
//  sel       in   SELW      channel index used in mode 0
//  out_data  out  DW        registered output data
//  out_valid out  1         output register holds a word
//  out_ready in   1         consumer accepts the word
//  out_ch    out  SELW      channel index of the word in out_data
//  xfer_cnt  out  16        output transfer count (present only with MUX_STATS_EN)
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0, xfer_cnt=0.
//    in_ready is forced to all-zero while rst=1.
//  - States: EMPTY (out_valid=0) and FULL (out_valid=1).
//    load_en = EMPTY | (FULL & out_ready).
//  - Grant selection (combinational):
//    mode 0: gnt = sel when sel<N_CH and in_valid[sel]=1; otherwise no grant.
//            sel>=N_CH never grants.
//    mode 1: gnt = first c with in_valid[c]=1, scanning rr_ptr, rr_ptr+1, ... mod N_CH;
//            no grant when in_valid is all zero.
//  - in_ready[c] = load_en & grant_valid & (c==gnt). At most one bit is set.
//    in_ready does not depend on in_valid of other channels beyond arbitration.
//  - Transfer in: when in_valid[gnt]&in_ready[gnt], on the next edge
//    out_data<=in_data[gnt], out_ch<=gnt, out_valid<=1. Latency is 1 cycle.
//  - Transfer out: when out_valid&out_ready with no new grant, out_valid<=0 (FULL->EMPTY).
//    With a simultaneous grant, the register reloads in the same edge (FULL->FULL).
//    This gives full throughput: 1 word/cycle.
//  - FULL & !out_ready: out_data, out_ch and out_valid hold stable; in_ready=0.
//  - rr_ptr updates only on an accepted input transfer: rr_ptr <= (gnt==N_CH-1) ? 0 : gnt+1.
//    It wraps at N_CH-1 -> 0. rr_ptr is unchanged by mode 0 transfers and by mode switches.
//  - Changes to mode/sel affect only the next grant; they never alter a word already registered.
//  - Reset asserted mid-operation discards the registered word. No in_ready is asserted that cycle.
// CONFIGURATION
//  - MUX_STATS_EN defined: xfer_cnt port exists. It increments by 1 on each out_valid&out_ready,
//    wraps 16'hFFFF -> 0, and is cleared by rst.
//  - MUX_STATS_EN undefined: xfer_cnt port and its counter are absent; all other behaviour is identical.
// TESTING
//  1 Reset: rst=1 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_ch=0.
//  2 Fixed mode, N_CH=16, DW=8: in_data[c]=8'h10+c, all valid, out_ready=1, sel stepped 0..15
//    (one per cycle) -> out_data=8'h10..8'h1F, each one cycle after its sel, with out_ch==sel.
//  3 Round-robin, all 16 valid, out_ready=1 -> out_ch sequence 0,1,...,15,0 on consecutive
//    cycles; then in_valid=16'h0081 -> out_ch alternates 7,0,7,0.
//  4 Backpressure: out_valid=1 (word 8'h15, ch 5), out_ready=0 for 4 cycles -> data/ch stable and
//    in_ready=0; when out_ready=1, the next word loads on the same edge with no bubble.
//  5 Boundary: mode 0, sel=3, in_valid[3]=0 -> no transfer, out_valid falls after drain.
//    mode 1 with in_valid=0 -> out_valid=0 and rr_ptr unchanged.
//  6 MUX_STATS_EN: 20 output transfers, then rst -> xfer_cnt reads 20 before reset and 0 after.
//    Preload-equivalent: 65536 transfers -> xfer_cnt wraps to 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N:1 streaming multiplexer with a registered output stage, fixed-select or round-robin arbitration.
// Optional transfer counter port xfer_cnt is built when MUX_STATS_EN is defined.
`timescale 1ns/1ps

module stream_mux_rr #(
    parameter int N_CH = 16,
    parameter int DW   = 8,
    parameter int SELW = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH*DW-1:0]   in_data,
    input  logic [N_CH-1:0]      in_valid,
    output logic [N_CH-1:0]      in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
`ifdef MUX_STATS_EN
    ,
    output logic [15:0]          xfer_cnt
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] gnt;
    logic            gnt_valid;
    logic            load_en;
    logic            take;
    int              idx;

    assign out_valid = (state_q == FULL);
    assign load_en   = (state_q == EMPTY) || out_ready;
    assign take      = load_en && gnt_valid && !rst;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        if (!mode) begin
            // An out-of-range sel matches no channel, so it never grants.
            for (int c = 0; c < N_CH; c++) begin
                if (SELW'(c) == sel && in_valid[c]) begin
                    gnt_valid = 1'b1;
                    gnt       = SELW'(c);
                end
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= N_CH) idx = idx - N_CH;
                if (!gnt_valid && in_valid[idx]) begin
                    gnt_valid = 1'b1;
                    gnt       = SELW'(idx);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int c = 0; c < N_CH; c++) begin
            in_ready[c] = take && (gnt == SELW'(c));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (take) state_d = FULL;
            FULL:  if (out_ready && !take) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_ch   <= '0;
            rr_ptr   <= '0;
        end else if (take) begin
            out_data <= in_data[int'(gnt)*DW +: DW];
            out_ch   <= gnt;
            // Mode 0 transfers leave the round-robin position untouched.
            if (mode) rr_ptr <= (gnt == SELW'(N_CH - 1)) ? '0 : gnt + 1'b1;
        end
    end

`ifdef MUX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)                         xfer_cnt <= '0;
        else if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
`timescale 1ns/1ps

module tb_stream_mux_rr;

    localparam int N_CH = 16;
    localparam int DW   = 8;
    localparam int SELW = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_CH*DW-1:0]  in_data;
    logic [N_CH-1:0]     in_valid;
    logic [N_CH-1:0]     in_ready;
    logic                mode;
    logic [SELW-1:0]     sel;
    logic [DW-1:0]       out_data;
    logic                out_valid;
    logic                out_ready;
    logic [SELW-1:0]     out_ch;
`ifdef MUX_STATS_EN
    logic [15:0]         xfer_cnt;
`endif

    stream_mux_rr #(.N_CH(N_CH), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
`ifdef MUX_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the word held at the output plus the round-robin start point.
    bit       m_valid;
    bit [7:0] m_data;
    int       m_ch;
    int       m_ptr;
    int       m_cnt;
    int       n_out_xfers;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    // Called at a negedge with inputs already applied; checks, clocks the model, returns at next negedge.
    task automatic cycle();
        int              g;
        bit              load;
        logic [N_CH-1:0] exp_rdy;
        #1;
        g = -1;
        if (!mode) begin
            if (int'(sel) < N_CH && in_valid[sel]) g = int'(sel);
        end else begin
            for (int k = 0; k < N_CH; k++)
                if (g < 0 && in_valid[(m_ptr + k) % N_CH]) g = (m_ptr + k) % N_CH;
        end
        load    = !m_valid || out_ready;
        exp_rdy = '0;
        if (!rst && load && g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check("out_data", 64'(out_data), 64'(m_data));
            check("out_ch", 64'(out_ch), 64'(m_ch));
        end
`ifdef MUX_STATS_EN
        check("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
`endif
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (m_valid && out_ready) begin
                m_cnt = (m_cnt + 1) % 65536;
                n_out_xfers++;
            end
            if (load && g >= 0) begin
                m_valid = 1;
                m_data  = in_data[g*DW +: DW];
                m_ch    = g;
                if (mode) m_ptr = (g + 1) % N_CH;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_ramp_data();
        for (int c = 0; c < N_CH; c++) in_data[c*DW +: DW] = 8'h10 + 8'(c);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = '1;
        cycle();
        cycle();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ch", 64'(out_ch), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; out_ready = 1'b1; in_valid = '1;
        set_ramp_data();
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_cnt = 0; n_out_xfers = 0;
        @(negedge clk);

        // Reset holds in_ready low even with every channel valid.
        do_reset();

        // Fixed select stepped across all channels.
        mode = 1'b0;
        for (int s = 0; s < N_CH; s++) begin
            sel = SELW'(s);
            cycle();
            check("fixed_data", 64'(out_data), 64'(8'h10 + s));
            check("fixed_ch", 64'(out_ch), 64'(s));
        end

        // Round-robin over all channels, then two sparse channels.
        do_reset();
        mode = 1'b1; in_valid = '1;
        for (int i = 0; i <= N_CH; i++) begin
            cycle();
            check("rr_all_ch", 64'(out_ch), 64'(i % N_CH));
        end
        in_valid = 16'h0081;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_sparse_ch", 64'(out_ch), (i % 2 == 0) ? 64'd7 : 64'd0);
        end

        // Backpressure: word 0x15 from channel 5 held, then replaced without a bubble.
        mode = 1'b0; sel = 4'd5; in_valid = '1; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0; sel = 4'd6;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("bp_data", 64'(out_data), 64'h15);
            check("bp_ch", 64'(out_ch), 64'd5);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release_data", 64'(out_data), 64'h16);
        check("bp_release_valid", 64'(out_valid), 64'd1);

        // Fixed select on an idle channel drains the output.
        sel = 4'd3; in_valid = 16'hFFF7;
        cycle();
        check("idle_sel_drain", 64'(out_valid), 64'd0);
        cycle();
        check("idle_sel_empty", 64'(out_valid), 64'd0);
        // Round-robin with nothing valid keeps its position (last rr grant was channel 0).
        mode = 1'b1; in_valid = '0;
        cycle();
        cycle();
        check("idle_rr_empty", 64'(out_valid), 64'd0);
        in_valid = '1;
        cycle();
        check("rr_ptr_kept", 64'(out_ch), 64'd1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < N_CH; c++) in_data[c*DW +: DW] = DW'($urandom);
            in_valid  = N_CH'($urandom & $urandom);
            mode      = 1'($urandom_range(0, 1));
            sel       = SELW'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;

`ifdef MUX_STATS_EN
        set_ramp_data();
        do_reset();
        mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        n_out_xfers = 0;
        while (n_out_xfers < 20) cycle();
        check("cnt_20", 64'(xfer_cnt), 64'd20);
        do_reset();
        check("cnt_cleared", 64'(xfer_cnt), 64'd0);
        n_out_xfers = 0;
        while (n_out_xfers < 65536) cycle();
        check("cnt_wrap", 64'(xfer_cnt), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
